tcam_hit_sequencer: RTL and testbench
=====================================

# tcam_hit_sequencer

Downstream stage of the TCAM memory (`Mem`). It takes one compare result at a time: the per-word HITLINE vector plus the PacketID that produced it. It then emits every matching word address as a stream of single-address beats with a valid/ready handshake, lowest address first. The stream drives the weight/destination lookup and spike-routing logic, so one incoming packet fans out to all matching synapse entries.

## Interface
Parameters:
- `Words`, 16, number of TCAM words (width of the hit vector)
- `AddressSize`, 4, word address width; `Words` ≤ 2^`AddressSize`
- `ID_Width`, 4, PacketID width

Ports:
- `clk`  in  1  single clock, rising-edge
- `rst_n`  in  1  reset, asynchronous and active-low
- `Hit_Valid_In`  in  1  compare result available this cycle
- `HitLine_In`  in  `Words`  per-word match vector, bit i = word i hit
- `PacketID_In`  in  `ID_Width`  PacketID of the compared packet
- `Hit_Ready_Out`  out  1  sequencer can accept a compare result
- `Addr_Valid_Out`  out  1  address beat valid
- `Addr_Out`  out  `AddressSize`  matching word address
- `PacketID_Out`  out  `ID_Width`  PacketID associated with the current beat
- `Last_Out`  out  1  current beat is the final match of this packet
- `Match_Cnt_Out`  out  `AddressSize`+1  popcount of the captured hit vector
- `Addr_Ready_In`  in  1  consumer accepts the beat
- `Miss_Out`  out  1  one-cycle pulse: captured hit vector was all zero

## Operation
- The FSM has two states, IDLE and SCAN.
- IDLE:
  - `Hit_Ready_Out`=1 and `Addr_Valid_Out`=0.
  - On `Hit_Valid_In`&`Hit_Ready_Out`, capture `HitLine_In` into the pending register. Capture `PacketID_In` into the ID register and the popcount into `Match_Cnt_Out`.
  - If the captured vector is non-zero, go to SCAN.
  - If it is zero, stay in IDLE and set `Miss_Out` for exactly the next cycle. `Match_Cnt_Out` becomes 0.
- SCAN:
  - `Addr_Valid_Out`=1.
  - `Addr_Out` is the index of the lowest set bit of the pending register, produced by a combinational priority encode from registered state.
  - `Last_Out`=1 when exactly one pending bit remains.
- Handshake:
  - A beat transfers when `Addr_Valid_Out`&`Addr_Ready_In` are both high at a rising edge.
  - On transfer, clear that bit from the pending register.
  - If the transferred beat had `Last_Out`=1, the pending register becomes zero and the FSM returns to IDLE.
- Stall: while `Addr_Ready_In`=0, `Addr_Out`, `PacketID_Out`, `Last_Out` and `Match_Cnt_Out` hold stable and `Addr_Valid_Out` stays high.
- Back-to-back acceptance: `Hit_Ready_Out` = IDLE | (SCAN & `Last_Out` & `Addr_Ready_In`). A new result offered on the cycle of the final transfer is captured at the same edge, with no bubble.
- `Hit_Valid_In` while `Hit_Ready_Out`=0 is ignored, not queued. Upstream holds the result until it is accepted.
- Bits of `HitLine_In` at index ≥ 2^`AddressSize` cannot exist by parameter rule. No masking is required.
- `Match_Cnt_Out` and `PacketID_Out` hold their last captured value in IDLE until the next capture.

## Timing
- Reset values:
  - state=IDLE, so `Hit_Ready_Out`=1.
  - `Addr_Valid_Out`=0, `Addr_Out`=0, `PacketID_Out`=0, `Last_Out`=0.
  - `Match_Cnt_Out`=0, `Miss_Out`=0.
  - Pending register = 0.
- Reset asserted mid-SCAN: all outputs go to their reset values immediately (asynchronous). In-flight matches are discarded.
- Latency: capture at edge N gives the first `Addr_Valid_Out` (or the `Miss_Out` pulse) in the cycle after edge N.
- Throughput: one address per cycle when `Addr_Ready_In` stays high. A packet with k hits occupies k cycles in SCAN.
- `Hit_Ready_Out`, `Addr_Out` and `Last_Out` are combinational from registered state plus `Addr_Ready_In`. All other outputs are registered.
- Worst case: all `Words` bits set gives `Words` beats and `Match_Cnt_Out`=`Words`; with the defaults, `Match_Cnt_Out`=16.

## Test plan
- **Reset:** hold `rst_n`=0 for 2 cycles. Required: every output at its reset value and `Hit_Ready_Out`=1. Release with no stimulus: outputs stay unchanged.
- **Single hit:** `HitLine_In`=16'h0002, `PacketID_In`=4'h5, `Addr_Ready_In`=1. Required: one beat with `Addr_Out`=1, `Last_Out`=1, `PacketID_Out`=5, `Match_Cnt_Out`=1. FSM back in IDLE the next cycle.
- **Multi hit with stall:** `HitLine_In`=16'h8421 and `Addr_Ready_In` pattern 1,0,1,0,1,1. Required: beats 0, 5, 10, 15 in order, each held stable during stall cycles. `Last_Out` high only on 15. `Match_Cnt_Out`=4.
- **Miss:** `HitLine_In`=16'h0000, `PacketID_In`=4'h3. Required: `Miss_Out` high for exactly 1 cycle, `Addr_Valid_Out` never asserted, `Match_Cnt_Out`=0, `Hit_Ready_Out` stays 1.
- **Back-to-back:** 16'h0003 (ID 1) followed immediately by 16'h0010 (ID 2), with `Hit_Valid_In` held until accepted. Required: beats 0 and 1 under ID 1, then 4 under ID 2, in consecutive cycles with no gap. A `Hit_Valid_In` offered during beat 0 is not accepted.
- **Reset mid-scan:** 16'hFFFF, drop `rst_n` after 3 transferred beats. Required: `Addr_Valid_Out`=0 at once. After release, the FSM is in IDLE with no further beats, and a new 16'h0100 yields a single beat with `Addr_Out`=8.

Source files
------------

// File: rtl/tcam_hit_sequencer.sv
// tcam_hit_sequencer: expands one TCAM hit vector into a lowest-first stream of matching word addresses
module tcam_hit_sequencer #(
    parameter int Words       = 16,
    parameter int AddressSize = 4,
    parameter int ID_Width    = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   Hit_Valid_In,
    input  logic [Words-1:0]       HitLine_In,
    input  logic [ID_Width-1:0]    PacketID_In,
    output logic                   Hit_Ready_Out,
    output logic                   Addr_Valid_Out,
    output logic [AddressSize-1:0] Addr_Out,
    output logic [ID_Width-1:0]    PacketID_Out,
    output logic                   Last_Out,
    output logic [AddressSize:0]   Match_Cnt_Out,
    input  logic                   Addr_Ready_In,
    output logic                   Miss_Out
);
    typedef enum logic {IDLE, SCAN} state_t;

    state_t                state, state_n;
    logic [Words-1:0]      pending, pending_n, low_bit;
    logic [ID_Width-1:0]   id_q;
    logic [AddressSize:0]  cnt_q, popcnt;
    logic                  miss_q, accept, xfer;

    assign PacketID_Out   = id_q;
    assign Match_Cnt_Out  = cnt_q;
    assign Miss_Out       = miss_q;
    assign Addr_Valid_Out = (state == SCAN);
    assign low_bit        = pending & (~pending + Words'(1));
    assign Last_Out       = (|pending) && ((pending & (pending - Words'(1))) == '0);

    // priority encode: lowest pending bit wins, so scan from the top down
    always_comb begin
        Addr_Out = '0;
        for (int i = Words - 1; i >= 0; i--)
            if (pending[i]) Addr_Out = AddressSize'(i);
    end

    // population count of the incoming hit vector
    always_comb begin
        popcnt = '0;
        for (int i = 0; i < Words; i++)
            popcnt = popcnt + (AddressSize + 1)'(HitLine_In[i]);
    end

    // next-state, handshake and pending-vector update; a capture overrides the final clear
    always_comb begin
        Hit_Ready_Out = (state == IDLE) || (state == SCAN && Last_Out && Addr_Ready_In);
        accept        = Hit_Valid_In && Hit_Ready_Out;
        xfer          = (state == SCAN) && Addr_Ready_In;
        state_n       = state;
        pending_n     = pending;
        if (xfer) pending_n = pending & ~low_bit;
        if (xfer && Last_Out) state_n = IDLE;
        if (accept) begin
            pending_n = HitLine_In;
            state_n   = (|HitLine_In) ? SCAN : IDLE;
        end
    end

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end

    // pending vector, captured packet attributes and miss pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending <= '0;
            id_q    <= '0;
            cnt_q   <= '0;
            miss_q  <= 1'b0;
        end else begin
            pending <= pending_n;
            miss_q  <= accept && !(|HitLine_In);
            if (accept) begin
                id_q  <= PacketID_In;
                cnt_q <= popcnt;
            end
        end
    end
endmodule

// File: tb/tb_tcam_hit_sequencer.sv
// tb_tcam_hit_sequencer: directed scenarios plus randomized traffic against a queue-based model
module tb_tcam_hit_sequencer;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        hv = 1'b0;
    logic [15:0] line = '0;
    logic [3:0]  pid = '0;
    logic        rdy = 1'b0;
    logic        hit_ready, addr_valid, last, miss;
    logic [3:0]  addr, id_out;
    logic [4:0]  cnt;
    logic [16:0] obs;
    int          checks = 0;
    int          errors = 0;

    tcam_hit_sequencer dut (
        .clk(clk), .rst_n(rst_n),
        .Hit_Valid_In(hv), .HitLine_In(line), .PacketID_In(pid),
        .Hit_Ready_Out(hit_ready), .Addr_Valid_Out(addr_valid), .Addr_Out(addr),
        .PacketID_Out(id_out), .Last_Out(last), .Match_Cnt_Out(cnt),
        .Addr_Ready_In(rdy), .Miss_Out(miss)
    );

    always #5 clk = ~clk;

    assign obs = {hit_ready, addr_valid, addr, last, id_out, cnt, miss};

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (2) tick();
        checks++;
        if (obs !== {1'b1, 1'b0, 4'd0, 1'b0, 4'd0, 5'd0, 1'b0}) begin
            errors++;
            $display("FAIL reset_hold: got %h want %h", obs, {1'b1, 1'b0, 4'd0, 1'b0, 4'd0, 5'd0, 1'b0});
        end
        rst_n = 1'b1;
        repeat (2) tick();
        checks++;
        if (obs !== {1'b1, 1'b0, 4'd0, 1'b0, 4'd0, 5'd0, 1'b0}) begin
            errors++;
            $display("FAIL reset_release: got %h want %h", obs, {1'b1, 1'b0, 4'd0, 1'b0, 4'd0, 5'd0, 1'b0});
        end
    endtask

    task automatic test_single;
        hv = 1'b1; line = 16'h0002; pid = 4'h5; rdy = 1'b1;
        #1;
        checks++;
        if (hit_ready !== 1'b1) begin
            errors++;
            $display("FAIL single_ready: got %b want 1", hit_ready);
        end
        tick();
        hv = 1'b0;
        #1;
        checks++;
        if (obs !== {1'b1, 1'b1, 4'd1, 1'b1, 4'd5, 5'd1, 1'b0}) begin
            errors++;
            $display("FAIL single_beat: got %h want %h", obs, {1'b1, 1'b1, 4'd1, 1'b1, 4'd5, 5'd1, 1'b0});
        end
        tick();
        checks++;
        if (obs !== {1'b1, 1'b0, 4'd0, 1'b0, 4'd5, 5'd1, 1'b0}) begin
            errors++;
            $display("FAIL single_idle: got %h want %h", obs, {1'b1, 1'b0, 4'd0, 1'b0, 4'd5, 5'd1, 1'b0});
        end
    endtask

    task automatic test_multi_stall;
        logic       pat [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        logic [3:0] ea  [6] = '{4'd0, 4'd5, 4'd5, 4'd10, 4'd10, 4'd15};
        logic       el  [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        hv = 1'b1; line = 16'h8421; pid = 4'h7; rdy = 1'b1;
        #1;
        tick();
        hv = 1'b0;
        for (int k = 0; k < 6; k++) begin
            rdy = pat[k];
            #1;
            checks++;
            if (obs !== {el[k] & pat[k], 1'b1, ea[k], el[k], 4'd7, 5'd4, 1'b0}) begin
                errors++;
                $display("FAIL multi_stall[%0d]: got %h want %h", k, obs, {el[k] & pat[k], 1'b1, ea[k], el[k], 4'd7, 5'd4, 1'b0});
            end
            tick();
        end
        checks++;
        if (addr_valid !== 1'b0 || hit_ready !== 1'b1) begin
            errors++;
            $display("FAIL multi_done: got valid=%b ready=%b want valid=0 ready=1", addr_valid, hit_ready);
        end
    endtask

    task automatic test_miss;
        hv = 1'b1; line = 16'h0000; pid = 4'h3; rdy = 1'b1;
        #1;
        tick();
        hv = 1'b0;
        #1;
        checks++;
        if (obs !== {1'b1, 1'b0, 4'd0, 1'b0, 4'd3, 5'd0, 1'b1}) begin
            errors++;
            $display("FAIL miss_pulse: got %h want %h", obs, {1'b1, 1'b0, 4'd0, 1'b0, 4'd3, 5'd0, 1'b1});
        end
        tick();
        checks++;
        if (obs !== {1'b1, 1'b0, 4'd0, 1'b0, 4'd3, 5'd0, 1'b0}) begin
            errors++;
            $display("FAIL miss_end: got %h want %h", obs, {1'b1, 1'b0, 4'd0, 1'b0, 4'd3, 5'd0, 1'b0});
        end
    endtask

    task automatic test_back_to_back;
        hv = 1'b1; line = 16'h0003; pid = 4'h1; rdy = 1'b1;
        #1;
        tick();
        line = 16'h0010; pid = 4'h2;
        #1;
        checks++;
        if (obs !== {1'b0, 1'b1, 4'd0, 1'b0, 4'd1, 5'd2, 1'b0}) begin
            errors++;
            $display("FAIL b2b_beat0: got %h want %h", obs, {1'b0, 1'b1, 4'd0, 1'b0, 4'd1, 5'd2, 1'b0});
        end
        tick();
        checks++;
        if (obs !== {1'b1, 1'b1, 4'd1, 1'b1, 4'd1, 5'd2, 1'b0}) begin
            errors++;
            $display("FAIL b2b_beat1: got %h want %h", obs, {1'b1, 1'b1, 4'd1, 1'b1, 4'd1, 5'd2, 1'b0});
        end
        tick();
        hv = 1'b0;
        #1;
        checks++;
        if (obs !== {1'b1, 1'b1, 4'd4, 1'b1, 4'd2, 5'd1, 1'b0}) begin
            errors++;
            $display("FAIL b2b_beat2: got %h want %h", obs, {1'b1, 1'b1, 4'd4, 1'b1, 4'd2, 5'd1, 1'b0});
        end
        tick();
        checks++;
        if (obs !== {1'b1, 1'b0, 4'd0, 1'b0, 4'd2, 5'd1, 1'b0}) begin
            errors++;
            $display("FAIL b2b_idle: got %h want %h", obs, {1'b1, 1'b0, 4'd0, 1'b0, 4'd2, 5'd1, 1'b0});
        end
    endtask

    task automatic test_reset_mid_scan;
        hv = 1'b1; line = 16'hFFFF; pid = 4'h6; rdy = 1'b1;
        #1;
        tick();
        hv = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++;
            if ({addr_valid, addr, last, id_out, cnt} !== {1'b1, 4'(k), 1'b0, 4'd6, 5'd16}) begin
                errors++;
                $display("FAIL full_beat[%0d]: got %h want %h", k, {addr_valid, addr, last, id_out, cnt}, {1'b1, 4'(k), 1'b0, 4'd6, 5'd16});
            end
            tick();
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (obs !== {1'b1, 1'b0, 4'd0, 1'b0, 4'd0, 5'd0, 1'b0}) begin
            errors++;
            $display("FAIL async_reset: got %h want %h", obs, {1'b1, 1'b0, 4'd0, 1'b0, 4'd0, 5'd0, 1'b0});
        end
        tick();
        rst_n = 1'b1;
        tick();
        checks++;
        if (obs !== {1'b1, 1'b0, 4'd0, 1'b0, 4'd0, 5'd0, 1'b0}) begin
            errors++;
            $display("FAIL post_reset_idle: got %h want %h", obs, {1'b1, 1'b0, 4'd0, 1'b0, 4'd0, 5'd0, 1'b0});
        end
        hv = 1'b1; line = 16'h0100; pid = 4'h9;
        #1;
        tick();
        hv = 1'b0;
        #1;
        checks++;
        if (obs !== {1'b1, 1'b1, 4'd8, 1'b1, 4'd9, 5'd1, 1'b0}) begin
            errors++;
            $display("FAIL post_reset_beat: got %h want %h", obs, {1'b1, 1'b1, 4'd8, 1'b1, 4'd9, 5'd1, 1'b0});
        end
        tick();
        checks++;
        if (addr_valid !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_done: got valid=%b want 0", addr_valid);
        end
    endtask

    task automatic test_random;
        int         q[$];
        logic [3:0] q_id = '0;
        logic [4:0] q_cnt = '0;
        logic       exp_miss = 1'b0;
        logic       exp_rdy, acc, xf;
        int         packets = 0;
        for (int cyc = 0; cyc < 20000 && packets < 200; cyc++) begin
            if (!hv && $urandom_range(0, 2) != 0) begin
                hv = 1'b1;
                pid = 4'($urandom);
                case ($urandom_range(0, 9))
                    0:       line = 16'h0000;
                    1:       line = 16'hFFFF;
                    default: line = 16'($urandom & $urandom);
                endcase
            end
            rdy = ($urandom_range(0, 3) != 0);
            #1;
            exp_rdy = (q.size() == 0) || (q.size() == 1 && rdy);
            checks++;
            if ({hit_ready, addr_valid, miss} !== {exp_rdy, q.size() != 0, exp_miss}) begin
                errors++;
                $display("FAIL rand_ctrl cyc %0d: got rdy/vld/miss=%b want %b", cyc, {hit_ready, addr_valid, miss}, {exp_rdy, q.size() != 0, exp_miss});
            end
            checks++;
            if (q.size() != 0 && {addr, last, id_out, cnt} !== {4'(q[0]), q.size() == 1, q_id, q_cnt}) begin
                errors++;
                $display("FAIL rand_beat cyc %0d: got %h want %h", cyc, {addr, last, id_out, cnt}, {4'(q[0]), q.size() == 1, q_id, q_cnt});
            end else if (q.size() == 0 && (last !== 1'b0 || (exp_miss && cnt !== 5'd0))) begin
                errors++;
                $display("FAIL rand_idle cyc %0d: got last=%b cnt=%0d want last=0", cyc, last, cnt);
            end
            acc = hv && exp_rdy;
            xf  = (q.size() != 0) && rdy;
            tick();
            if (xf) void'(q.pop_front());
            exp_miss = acc && (line == 16'h0000);
            if (acc) begin
                for (int b = 0; b < 16; b++)
                    if (line[b]) q.push_back(b);
                q_id  = pid;
                q_cnt = 5'($countones(line));
                packets++;
                hv = 1'b0;
            end
        end
        checks++;
        if (packets < 200) begin
            errors++;
            $display("FAIL rand_timeout: got %0d packets want 200", packets);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_multi_stall();
        test_miss();
        test_back_to_back();
        test_reset_mid_scan();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
